// File: rtl/pixel_readout_sequencer.sv
// Frame-level sequencer for the pixel array: global erase, global exposure,
// then a row-by-row walk (select, convert, release) with per-row timeouts.
// Every output is a flop loaded from the next-state decode, so outputs
// change together with the state register.
module pixel_readout_sequencer #(
    parameter int ROWS           = 3,
    parameter int WIDTH          = 2,
    parameter int ERASE_CYCLES   = 4,
    parameter int EXPOSE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             continuous,
    input  logic             row_done,
    output logic             ERASE,
    output logic             EXPOSE,
    output logic             enable,
    output logic [WIDTH-1:0] decoder_select,
    output logic             busy,
    output logic             frame_done,
    output logic             timeout_err
);

    localparam logic [CNT_WIDTH-1:0] ERASE_LAST   = CNT_WIDTH'(ERASE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] EXPOSE_LAST  = CNT_WIDTH'(EXPOSE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [WIDTH-1:0]     LAST_ROW     = WIDTH'(ROWS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE_PH,
        ST_EXPOSE_PH,
        ST_SELECT,
        ST_CONVERT,
        ST_RELEASE,
        ST_FRAME_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     row_q, row_d;
    logic [WIDTH-1:0]     sel_q, sel_d;
    logic                 row_done_q;
    logic                 erase_q, erase_d;
    logic                 expose_q, expose_d;
    logic                 enable_q, enable_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 timeout_q, timeout_d;

    // Next-state, counter, row index and sticky timeout; outputs decoded from the next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_ERASE_PH;
                    cnt_d     = '0;
                    row_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_ERASE_PH: begin
                if (cnt_q == ERASE_LAST) begin
                    state_d = ST_EXPOSE_PH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_EXPOSE_PH: begin
                if (cnt_q == EXPOSE_LAST) begin
                    state_d = ST_SELECT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_SELECT: begin
                state_d = ST_CONVERT;
                cnt_d   = '0;
            end
            ST_CONVERT: begin
                if (row_done_q) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = ST_RELEASE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_RELEASE: begin
                if (!row_done_q || cnt_q == TIMEOUT_LAST) begin
                    if (row_done_q) begin
                        timeout_d = 1'b1;
                    end
                    cnt_d = '0;
                    if (row_q == LAST_ROW) begin
                        state_d = ST_FRAME_DONE;
                    end else begin
                        state_d = ST_SELECT;
                        row_d   = row_q + WIDTH'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_FRAME_DONE: begin
                if (continuous) begin
                    state_d = ST_ERASE_PH;
                    cnt_d   = '0;
                    row_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                row_d   = '0;
            end
        endcase

        erase_d      = (state_d == ST_ERASE_PH);
        expose_d     = (state_d == ST_EXPOSE_PH);
        enable_d     = (state_d == ST_CONVERT);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_FRAME_DONE);

        case (state_d)
            ST_IDLE:   sel_d = '0;
            ST_SELECT: sel_d = row_d;
            default:   sel_d = sel_q;
        endcase
    end

    // State, counters and registered outputs; reset drops every output immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            row_q        <= '0;
            sel_q        <= '0;
            row_done_q   <= 1'b0;
            erase_q      <= 1'b0;
            expose_q     <= 1'b0;
            enable_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            sel_q        <= sel_d;
            row_done_q   <= row_done;
            erase_q      <= erase_d;
            expose_q     <= expose_d;
            enable_q     <= enable_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign ERASE          = erase_q;
    assign EXPOSE         = expose_q;
    assign enable         = enable_q;
    assign decoder_select = sel_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign timeout_err    = timeout_q;

endmodule
